// File: rtl/car_pkg.sv
// Shared constants, VGA register map, FSM state type and bus payload for the car controller.
package car_pkg;

    localparam int unsigned X_W = 10;

    localparam logic [X_W-1:0] X_MIN  = 10'd175;
    localparam logic [X_W-1:0] X_MAX  = 10'd420;
    localparam logic [X_W-1:0] X_INIT = 10'd269;
    localparam logic [X_W-1:0] STEP   = 10'd10;

    // VGA peripheral register offsets
    localparam logic [31:0] REG_POS  = 32'h0000_0000;
    localparam logic [31:0] REG_DATA = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_INIT_WR = 2'd0,
        ST_IDLE    = 2'd1,
        ST_WRITE   = 2'd2
    } car_state_e;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wb_wr_t;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for the asynchronous pushbutton levels.
module btn_sync #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/wb_car_ctrl_master.sv
// Wishbone initiator that turns rate-limited button presses into writes of the
// car X coordinate to the VGA position register.
module wb_car_ctrl_master #(
    parameter logic [31:0] VGA_BASE = 32'h0000_0000,
    parameter int unsigned MOVE_DIV = 500000,
    parameter logic [9:0]  STEP     = car_pkg::STEP,
    parameter logic [9:0]  X_MIN    = car_pkg::X_MIN,
    parameter logic [9:0]  X_MAX    = car_pkg::X_MAX,
    parameter logic [9:0]  X_INIT   = car_pkg::X_INIT,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        enable,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic [9:0]  car_x_o,
    output logic        busy_o,
    output logic        err_o
);

    import car_pkg::*;

    localparam int unsigned      CNT_W      = $clog2(MOVE_DIV);
    localparam int unsigned      TO_W       = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MOVE_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [10:0]      LEFT_FLOOR = 11'(X_MIN) + 11'(STEP);

    logic [1:0]       btn_s;
    car_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    wb_wr_t           wr_q, wr_d;
    logic [9:0]       pend_q, pend_d, car_x_q, car_x_d;
    logic             busy_q, busy_d, err_q, err_d;

    logic             tick_c, move_c, start_c, end_c;
    logic [10:0]      sum_c;
    logic [9:0]       left_x_c, right_x_c, tgt_x_c, start_x_c;
    logic             unused_dat_c;

    btn_sync #(.WIDTH(2)) u_btn_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d_i ({btn_left, btn_right}),
        .q_o (btn_s)
    );

    // Read data is never consumed by a write-only master.
    assign unused_dat_c = ^wbm_dat_i;

    // Clamped move targets; left compares before subtracting so it cannot wrap.
    always_comb begin
        tick_c    = (cnt_q == CNT_LAST);
        sum_c     = 11'(car_x_q) + 11'(STEP);
        right_x_c = (sum_c > 11'(X_MAX)) ? X_MAX : sum_c[9:0];
        left_x_c  = (11'(car_x_q) >= LEFT_FLOOR) ? (car_x_q - STEP) : X_MIN;
        tgt_x_c   = btn_s[1] ? left_x_c : right_x_c;
        move_c    = tick_c & enable & (btn_s[1] ^ btn_s[0]);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = tick_c ? '0 : (cnt_q + CNT_W'(1));
        to_d      = to_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        wr_d      = wr_q;
        pend_d    = pend_q;
        car_x_d   = car_x_q;
        busy_d    = busy_q;
        err_d     = err_q;
        start_c   = 1'b0;
        end_c     = 1'b0;
        start_x_c = X_INIT;

        case (state_q)
            ST_INIT_WR: begin
                start_c   = 1'b1;
                start_x_c = X_INIT;
            end
            ST_IDLE: begin
                // Ticks landing in other states are simply dropped.
                if (move_c && (tgt_x_c != car_x_q)) begin
                    start_c   = 1'b1;
                    start_x_c = tgt_x_c;
                end
            end
            ST_WRITE: begin
                if (wbm_err_i) begin
                    end_c = 1'b1;
                    err_d = 1'b1;
                end else if (wbm_ack_i) begin
                    end_c   = 1'b1;
                    car_x_d = pend_q;
                    err_d   = 1'b0;
                end else if (to_q == TO_LAST) begin
                    end_c = 1'b1;
                    err_d = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_c) begin
            state_d = ST_WRITE;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b1;
            wr_d    = '{adr: VGA_BASE + REG_POS, dat: 32'(start_x_c), sel: 4'hF};
            pend_d  = start_x_c;
            busy_d  = 1'b1;
            to_d    = '0;
        end

        // Returning to IDLE guarantees at least one idle bus cycle before the next start.
        if (end_c) begin
            state_d = ST_IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            wr_d    = '0;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_INIT_WR;
            cnt_q   <= '0;
            to_q    <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            wr_q    <= '0;
            pend_q  <= X_INIT;
            car_x_q <= X_INIT;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            wr_q    <= wr_d;
            pend_q  <= pend_d;
            car_x_q <= car_x_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = wr_q.adr;
    assign wbm_dat_o = wr_q.dat;
    assign wbm_sel_o = wr_q.sel;
    assign car_x_o   = car_x_q;
    assign busy_o    = busy_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_wb_car_ctrl_master.sv
// Bench for wb_car_ctrl_master: directed and random button windows checked
// against a coordinate-level model of car movement and bus transactions.
module tb_wb_car_ctrl_master;

    localparam int unsigned MOVE_DIV = 8;
    localparam int unsigned TIMEOUT  = 4;
    localparam logic [31:0] VGA_BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_left = 1'b0, btn_right = 1'b0, enable = 1'b0;
    logic        cyc, stb, we;
    logic [31:0] adr, dat, dat_i;
    logic [3:0]  sel;
    logic        ack, err;
    logic [9:0]  car_x;
    logic        busy, err_flag;

    int checks = 0;
    int errors = 0;
    int mode   = 0;   // slave behaviour: 0 ack, 1 silent, 2 ack+err together

    always #5 clk = ~clk;

    wb_car_ctrl_master #(
        .VGA_BASE (VGA_BASE),
        .MOVE_DIV (MOVE_DIV),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .enable    (enable),
        .wbm_cyc_o (cyc),
        .wbm_stb_o (stb),
        .wbm_we_o  (we),
        .wbm_adr_o (adr),
        .wbm_dat_o (dat),
        .wbm_sel_o (sel),
        .wbm_dat_i (dat_i),
        .wbm_ack_i (ack),
        .wbm_err_i (err),
        .car_x_o   (car_x),
        .busy_o    (busy),
        .err_o     (err_flag)
    );

    // Slave: terminates one cycle after seeing stb; read data is noise.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack   <= 1'b0;
            err   <= 1'b0;
            dat_i <= '0;
        end else begin
            dat_i <= $urandom;
            if (cyc && stb && !ack && !err) begin
                ack <= (mode == 0) || (mode == 2);
                err <= (mode == 2);
            end else begin
                ack <= 1'b0;
                err <= 1'b0;
            end
        end
    end

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          len;
        int          gap;
        bit          stable;
    } tr_t;

    tr_t  mon_q[$];
    logic prev_cyc = 1'b0;
    logic [31:0] c_adr = '0, c_dat = '0;
    logic [3:0]  c_sel = '0;
    int   len = 0, gap = 1000, c_gap = 0;
    bit   stable = 1'b0;

    // Bus monitor: one record per cycle, with its length and the idle gap before it.
    always @(negedge clk) begin
        prev_cyc <= cyc;
        if (cyc) begin
            if (!prev_cyc) begin
                c_adr  <= adr;
                c_dat  <= dat;
                c_sel  <= sel;
                stable <= stb && we;
                len    <= 1;
                c_gap  <= gap;
            end else begin
                len <= len + 1;
                if (adr !== c_adr || dat !== c_dat || sel !== c_sel || !stb || !we)
                    stable <= 1'b0;
            end
        end else begin
            if (prev_cyc) begin
                mon_q.push_back('{c_adr, c_dat, c_sel, len, c_gap, stable});
                gap <= 1;
            end else begin
                gap <= gap + 1;
            end
        end
    end

    int         x_model   = 269;
    bit         err_model = 1'b0;
    logic [9:0] exp_q[$];
    int         exp_len[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int move(input int x, input bit l);
        int v;
        v = l ? x - 10 : x + 10;
        if (v < 175) v = 175;
        if (v > 420) v = 420;
        return v;
    endfunction

    task automatic check_queue(input string tag);
        int n;
        check({tag, ".count"}, mon_q.size(), exp_q.size());
        n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.adr%0d", tag, i), mon_q[i].adr, VGA_BASE);
            check($sformatf("%s.sel%0d", tag, i), 32'(mon_q[i].sel), 32'hF);
            check($sformatf("%s.dat%0d", tag, i), mon_q[i].dat, 32'(exp_q[i]));
            check($sformatf("%s.len%0d", tag, i), mon_q[i].len, exp_len[i]);
            check($sformatf("%s.stable%0d", tag, i), 32'(mon_q[i].stable), 1);
            check($sformatf("%s.gap%0d", tag, i), 32'(mon_q[i].gap >= 1), 1);
        end
        mon_q.delete();
        exp_q.delete();
        exp_len.delete();
    endtask

    task automatic check_state(input string tag);
        check({tag, ".car_x"}, 32'(car_x), x_model);
        check({tag, ".err"}, 32'(err_flag), 32'(err_model));
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".cyc"}, 32'(cyc), 0);
    endtask

    // Called at the negedge after a tick edge; holds buttons for n ticks plus one quiet tick.
    task automatic run_window(input bit l, input bit r, input bit e, input int n, input string tag);
        int v;
        btn_left  = l;
        btn_right = r;
        enable    = e;
        for (int i = 0; i < n; i++) begin
            if (e && (l ^ r)) begin
                v = move(x_model, l);
                if (v != x_model) begin
                    exp_q.push_back(10'(v));
                    exp_len.push_back((mode == 1) ? TIMEOUT : 2);
                    if (mode == 0) begin
                        x_model   = v;
                        err_model = 1'b0;
                    end else begin
                        err_model = 1'b1;
                    end
                end
            end
        end
        repeat (8 * n) @(posedge clk);
        @(negedge clk);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_queue(tag);
        check_state(tag);
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic release_and_align();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int  v;
        bit  rl, rr, re;
        int  rn;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.cyc", 32'(cyc), 0);
        check("rst.stb", 32'(stb), 0);
        check("rst.we", 32'(we), 0);
        check("rst.adr", adr, 0);
        check("rst.dat", dat, 0);
        check("rst.sel", 32'(sel), 0);
        check("rst.car_x", 32'(car_x), 269);
        check("rst.busy", 32'(busy), 0);
        check("rst.err", 32'(err_flag), 0);

        enable = 1'b1;
        release_and_align();
        exp_q.push_back(10'h10D);
        exp_len.push_back(2);
        check_queue("init");
        check_state("init");

        run_window(1'b0, 1'b0, 1'b1, 13, "quiet");
        run_window(1'b0, 1'b1, 1'b1, 3, "right3");
        check("right3.x299", 32'(car_x), 299);
        run_window(1'b1, 1'b0, 1'b1, 14, "to_left");
        run_window(1'b0, 1'b1, 1'b1, 24, "to_415");
        check("to_415.x", 32'(car_x), 415);
        run_window(1'b0, 1'b1, 1'b1, 2, "right_wall");
        check("right_wall.x", 32'(car_x), 420);
        run_window(1'b1, 1'b0, 1'b1, 24, "to_180");
        check("to_180.x", 32'(car_x), 180);
        run_window(1'b1, 1'b0, 1'b1, 2, "left_wall");
        check("left_wall.x", 32'(car_x), 175);
        run_window(1'b1, 1'b1, 1'b1, 10, "both");
        run_window(1'b0, 1'b1, 1'b0, 10, "disabled");

        mode = 1;
        run_window(1'b0, 1'b1, 1'b1, 1, "timeout");
        mode = 0;
        run_window(1'b0, 1'b1, 1'b1, 1, "recover");
        mode = 2;
        run_window(1'b0, 1'b1, 1'b1, 1, "ack_err");
        mode = 0;
        run_window(1'b1, 1'b0, 1'b1, 1, "recover2");

        for (int k = 0; k < 12; k++) begin
            rl = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            re = ($urandom_range(0, 3) != 0);
            rn = $urandom_range(1, 4);
            run_window(rl, rr, re, rn, $sformatf("rand%0d", k));
        end

        // Reset while a cycle is outstanding.
        run_window(1'b1, 1'b0, 1'b1, 2, "pre_rst");
        mode      = 1;
        btn_right = 1'b1;
        v = move(x_model, 1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("mid.cyc", 32'(cyc), 1);
        check("mid.busy", 32'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst.cyc", 32'(cyc), 0);
        check("mid_rst.stb", 32'(stb), 0);
        btn_right = 1'b0;
        mode      = 0;
        repeat (2) @(posedge clk);
        release_and_align();
        exp_q.push_back(10'(v));
        exp_len.push_back(1);
        exp_q.push_back(10'd269);
        exp_len.push_back(2);
        x_model   = 269;
        err_model = 1'b0;
        check_queue("after_rst");
        check_state("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_car_ctrl_master.md
Name: wb_car_ctrl_master

Overview:
- Wishbone initiator that steers the player car.
- Samples the left/right pushbuttons and rate-limits movement with a tick counter.
- Issues single 32-bit Wishbone write cycles to the VGA peripheral's car-position register (offset 0x0) with the new X coordinate.
- Sits between the board buttons and the VGA slave on the shared bus. It replaces software polling for car movement.

Parameters:
- VGA_BASE, 32'h0000_0000, byte address of the VGA peripheral. The position register is at VGA_BASE+0.
- MOVE_DIV, 500000, wb_clk_i cycles between movement ticks. Must be >= 2.
- STEP, 10'd10, pixels moved per tick.
- X_MIN, 10'd175, leftmost legal car X.
- X_MAX, 10'd420, rightmost legal car X.
- X_INIT, 10'd269, X written once after reset.
- TIMEOUT, 16, cycles to wait for ack/err before abandoning a cycle.

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_i  in  1  reset
- btn_left  in  1  raw left button, asynchronous, active-high
- btn_right  in  1  raw right button, asynchronous, active-high
- enable  in  1  movement enable. Synchronous to wb_clk_i.
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  write enable. Always 1 during a cycle.
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_sel_o  out  4  byte selects
- wbm_dat_i  in  32  read data. Unused; must be ignored.
- wbm_ack_i  in  1  normal termination
- wbm_err_i  in  1  error termination
- car_x_o  out  10  last X acknowledged by the slave
- busy_o  out  1  high while a bus cycle is outstanding
- err_o  out  1  sticky bus-error/timeout flag

Behaviour:
- Reset: wb_rst_i is asynchronous, active-high; clock is wb_clk_i.
- Reset values:
  - cyc, stb, we = 0; adr, dat, sel = 0
  - car_x_o = X_INIT; busy_o = 0; err_o = 0
  - tick counter = 0; FSM = INIT_WR
- Buttons: 2-flop synchroniser each. Only synchronised levels are used; no debounce beyond tick rate-limiting.
- Tick counter: counts 0..MOVE_DIV-1 and wraps. tick = 1 for one cycle when count == MOVE_DIV-1. Runs in all states. A tick arriving outside IDLE is dropped, not queued.
- FSM states: INIT_WR, IDLE, WRITE.
  - INIT_WR: first cycle after reset release, start a write of X_INIT, then go to WRITE. pend_x = X_INIT.
  - IDLE: on tick & enable & (left XOR right):
    - left: pend_x = max(car_x_o - STEP, X_MIN). The computation must not underflow; compare before subtracting.
    - right: pend_x = min(car_x_o + STEP, X_MAX). Compute in 11 bits.
    - If pend_x != car_x_o, go to WRITE. Otherwise stay in IDLE; no bus cycle at the wall.
    - Both buttons, neither button, or enable=0: no action.
  - WRITE:
    - Bus signals, registered and stable until termination: cyc = stb = we = 1, adr = VGA_BASE, sel = 4'hF, dat = {22'b0, pend_x}. busy_o = 1.
    - On ack: drop cyc/stb in the next cycle. car_x_o <= pend_x. err_o <= 0. Go to IDLE.
    - On err, or when TIMEOUT cycles have elapsed without termination: drop cyc/stb. car_x_o unchanged. err_o <= 1. Go to IDLE; there is no retry.
    - If ack and err arrive together, err wins.
- The slave terminates with ack one cycle after stb and requires at least one idle cycle between transfers. The master therefore holds cyc/stb low for at least 1 cycle after every termination before starting another cycle.
- Reset mid-cycle: cyc/stb drop immediately (asynchronously). After release, the FSM restarts at INIT_WR and car_x_o = X_INIT.
- Outputs are fully registered; there is no combinational path from wbm_ack_i to any wbm_* output.

Decomposition:
- Shared package car_pkg holds:
  - constants X_MIN, X_MAX, X_INIT, STEP
  - VGA register offsets: POS = 0x0, DATA = 0x4
  - FSM state enum
- One sub-module: btn_sync (2-flop synchroniser, parameterised width 2).

Test Plan:
- The bench uses MOVE_DIV = 8, TIMEOUT = 4, and a slave model that acks 1 cycle after stb.
- Scenario 1: Reset release, no buttons -> exactly one write with adr = VGA_BASE, dat = 0x10D, sel = F; then car_x_o = 269, err_o = 0; no further cycles for 100 clocks.
- Scenario 2: Hold btn_right for 3 ticks -> three writes with dat 279, 289, 299; car_x_o = 299; cyc low for at least 1 cycle between writes.
- Scenario 3: Start at X = 415, press btn_right -> write 420. Next tick -> no bus cycle; car_x_o stays 420. Mirror case at the left wall: start 180, press btn_left -> write 175, then no further cycle.
- Scenario 4: btn_left and btn_right held together, or enable = 0 -> zero bus cycles over 10 ticks.
- Scenario 5: Slave never acks -> cyc drops after 4 cycles; err_o = 1; car_x_o unchanged. A later successful ack clears err_o. A slave that asserts ack and err together -> err_o = 1 and no commit.
- Scenario 6: Assert wb_rst_i while cyc = 1 -> cyc/stb fall in the same cycle. After release, an INIT_WR write of 269 occurs.
